// File: rtl/voice_allocator_pkg.sv
// Shared types for the voice allocator: packet layout, per-voice field widths and FSM states.
// The allocator drives these packets straight into the tone generators.
package voice_allocator_pkg;

   localparam int PACKET_SIZE = 24;
   localparam int TUNE_W      = 16;
   localparam int VOL_W       = 8;
   localparam int KEY_W       = 7;
   localparam int AGE_W       = 8;

   localparam logic [AGE_W-1:0] AGE_MAX = '1;

   typedef logic [PACKET_SIZE-1:0] packetType;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SCAN   = 2'd1,
      COMMIT = 2'd2
   } state_t;

   function automatic packetType make_packet(input logic [TUNE_W-1:0] tune,
                                             input logic [VOL_W-1:0]  vol);
      return {tune, vol};
   endfunction

endpackage

// File: rtl/voice_allocator_voice_slot.sv
// One tone-generator track: packet, key, active flag and saturating age.
// Load wins over release, which wins over ageing.
module voice_slot
   import voice_allocator_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic             age_up,
   input  logic             release_note,
   input  packetType        load_packet,
   input  logic [KEY_W-1:0] load_key,
   output packetType        packet,
   output logic [KEY_W-1:0] key,
   output logic             active,
   output logic [AGE_W-1:0] age
);

   always_ff @(posedge clk) begin
      if (!reset) begin
         packet <= '0;
         key    <= '0;
         active <= 1'b0;
         age    <= '0;
      end else if (load) begin
         packet <= load_packet;
         key    <= load_key;
         active <= 1'b1;
         age    <= '0;
      end else if (release_note) begin
         // Tune word and key stay so the track can be inspected after release.
         packet[VOL_W-1:0] <= '0;
         active            <= 1'b0;
      end else if (age_up && active && (age != AGE_MAX)) begin
         age <= age + 1'b1;
      end
   end

endmodule

// File: rtl/voice_allocator.sv
// Note-event voice allocator: scans the voices one per cycle, then retriggers, allocates,
// steals the oldest voice or releases, updating all tracks in a single commit edge.
//
// state  | meaning
// IDLE   | evReady high, waiting for a note event
// SCAN   | examine voice scan_idx: key match, first free, oldest active
// COMMIT | apply the decision to the voice slots; stealPulse follows
module voice_allocator #(
   parameter int NUM_VOICES  = 4,
   parameter int PACKET_SIZE = 24
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              evValid,
   output logic                              evReady,
   input  logic                              evNoteOn,
   input  logic [6:0]                        evKey,
   input  logic [15:0]                       evTuneWord,
   input  logic [7:0]                        evVolume,
   output logic [NUM_VOICES*PACKET_SIZE-1:0] notePackets,
   output logic [NUM_VOICES-1:0]             voiceActive,
   output logic                              stealPulse
);
   import voice_allocator_pkg::*;

   localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);

   state_t              state;
   logic [IDX_W-1:0]    scan_idx;

   logic                ev_on;
   logic [KEY_W-1:0]    ev_key;
   logic [TUNE_W-1:0]   ev_tune;
   logic [VOL_W-1:0]    ev_vol;

   logic                match_hit;
   logic [IDX_W-1:0]    match_idx;
   logic                free_hit;
   logic [IDX_W-1:0]    free_idx;
   logic                old_hit;
   logic [IDX_W-1:0]    old_idx;
   logic [AGE_W-1:0]    old_age;

   packetType           slot_packet [NUM_VOICES];
   logic [KEY_W-1:0]    slot_key    [NUM_VOICES];
   logic [AGE_W-1:0]    slot_age    [NUM_VOICES];
   logic [NUM_VOICES-1:0] slot_active;

   logic [NUM_VOICES-1:0] slot_load;
   logic [NUM_VOICES-1:0] slot_age_up;
   logic [NUM_VOICES-1:0] slot_rel;

   logic                cur_active;
   logic [KEY_W-1:0]    cur_key;
   logic [AGE_W-1:0]    cur_age;
   logic [IDX_W-1:0]    target;
   logic                do_steal;

   // Ready is held low through reset so nothing can be accepted on the reset edge.
   assign evReady = reset && (state == IDLE);

   assign cur_active = slot_active[scan_idx];
   assign cur_key    = slot_key[scan_idx];
   assign cur_age    = slot_age[scan_idx];

   assign do_steal = ev_on && !match_hit && !free_hit;

   always_comb begin
      target = old_idx;
      if (free_hit)  target = free_idx;
      if (match_hit) target = match_idx;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state      <= IDLE;
         scan_idx   <= '0;
         ev_on      <= 1'b0;
         ev_key     <= '0;
         ev_tune    <= '0;
         ev_vol     <= '0;
         match_hit  <= 1'b0;
         match_idx  <= '0;
         free_hit   <= 1'b0;
         free_idx   <= '0;
         old_hit    <= 1'b0;
         old_idx    <= '0;
         old_age    <= '0;
         stealPulse <= 1'b0;
      end else begin
         stealPulse <= 1'b0;
         case (state)
            IDLE: begin
               if (evValid) begin
                  // A zero-volume note-on is folded into a note-off here.
                  ev_on     <= evNoteOn && (evVolume != '0);
                  ev_key    <= evKey;
                  ev_tune   <= evTuneWord;
                  ev_vol    <= evVolume;
                  match_hit <= 1'b0;
                  free_hit  <= 1'b0;
                  old_hit   <= 1'b0;
                  match_idx <= '0;
                  free_idx  <= '0;
                  old_idx   <= '0;
                  old_age   <= '0;
                  scan_idx  <= '0;
                  state     <= SCAN;
               end
            end
            SCAN: begin
               if (cur_active && (cur_key == ev_key) && !match_hit) begin
                  match_hit <= 1'b1;
                  match_idx <= scan_idx;
               end
               if (!cur_active && !free_hit) begin
                  free_hit <= 1'b1;
                  free_idx <= scan_idx;
               end
               // Strictly greater keeps the lowest index on equal ages.
               if (cur_active && (!old_hit || (cur_age > old_age))) begin
                  old_hit <= 1'b1;
                  old_idx <= scan_idx;
                  old_age <= cur_age;
               end
               if (scan_idx == LAST_IDX) begin
                  state <= COMMIT;
               end else begin
                  scan_idx <= scan_idx + 1'b1;
               end
            end
            COMMIT: begin
               stealPulse <= do_steal;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_comb begin
      slot_load   = '0;
      slot_age_up = '0;
      slot_rel    = '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
         if ((state == COMMIT) && ev_on) begin
            if (target == IDX_W'(i)) slot_load[i]   = 1'b1;
            else                     slot_age_up[i] = 1'b1;
         end
         if ((state == COMMIT) && !ev_on && match_hit && (match_idx == IDX_W'(i))) begin
            slot_rel[i] = 1'b1;
         end
      end
   end

   for (genvar g = 0; g < NUM_VOICES; g++) begin : g_voice
      voice_slot u_slot (
         .clk          (clk),
         .reset        (reset),
         .load         (slot_load[g]),
         .age_up       (slot_age_up[g]),
         .release_note (slot_rel[g]),
         .load_packet  (make_packet(ev_tune, ev_vol)),
         .load_key     (ev_key),
         .packet       (slot_packet[g]),
         .key          (slot_key[g]),
         .active       (slot_active[g]),
         .age          (slot_age[g])
      );
      assign notePackets[PACKET_SIZE*g +: PACKET_SIZE] = slot_packet[g];
   end

   assign voiceActive = slot_active;

endmodule

// File: tb/tb_voice_allocator.sv
// Directed bench for voice_allocator: allocation, retrigger, steal, release, back-to-back
// acceptance and reset mid-scan, with hand-computed expected packets.
module tb_voice_allocator;

   localparam int NV = 4;
   localparam int PS = 24;

   logic           clk;
   logic           reset;
   logic           evValid;
   logic           evReady;
   logic           evNoteOn;
   logic [6:0]     evKey;
   logic [15:0]    evTuneWord;
   logic [7:0]     evVolume;
   logic [NV*PS-1:0] notePackets;
   logic [NV-1:0]  voiceActive;
   logic           stealPulse;

   int checks;
   int errors;

   voice_allocator #(.NUM_VOICES(NV), .PACKET_SIZE(PS)) dut (
      .clk         (clk),
      .reset       (reset),
      .evValid     (evValid),
      .evReady     (evReady),
      .evNoteOn    (evNoteOn),
      .evKey       (evKey),
      .evTuneWord  (evTuneWord),
      .evVolume    (evVolume),
      .notePackets (notePackets),
      .voiceActive (voiceActive),
      .stealPulse  (stealPulse)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      reset = 1'b0;
      tick(2);
      reset = 1'b1;
      #1;
   endtask

   // Waits (bounded) for ready, presents one event and returns just after the accept edge.
   task automatic send(input logic on, input logic [6:0] k, input logic [15:0] t, input logic [7:0] v);
      int w;
      w = 0;
      while (!evReady && w < 20) begin
         tick(1);
         w++;
      end
      checks++;
      if (evReady !== 1'b1) begin
         errors++;
         $display("FAIL ready_wait: evReady=%b required 1 within 20 cycles", evReady);
      end
      evValid    = 1'b1;
      evNoteOn   = on;
      evKey      = k;
      evTuneWord = t;
      evVolume   = v;
      tick(1);
      evValid    = 1'b0;
   endtask

   // Event plus the NV+1 edges up to and including the commit edge.
   task automatic do_event(input logic on, input logic [6:0] k, input logic [15:0] t, input logic [7:0] v);
      send(on, k, t, v);
      tick(NV + 1);
   endtask

   task automatic test_reset();
      tick(2);
      checks++;
      if (evReady !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b required 0", evReady); end
      checks++;
      if (notePackets !== '0) begin errors++; $display("FAIL rst_packets: got %h required 0", notePackets); end
      checks++;
      if (voiceActive !== '0) begin errors++; $display("FAIL rst_active: got %b required 0", voiceActive); end
      checks++;
      if (stealPulse !== 1'b0) begin errors++; $display("FAIL rst_steal: got %b required 0", stealPulse); end
      reset = 1'b1;
      #1;
      checks++;
      if (evReady !== 1'b1) begin errors++; $display("FAIL rst_release_ready: got %b required 1", evReady); end
   endtask

   task automatic test_single_note();
      send(1'b1, 7'd60, 16'h0100, 8'h80);
      checks++;
      if (evReady !== 1'b0) begin errors++; $display("FAIL busy_ready: got %b required 0", evReady); end
      tick(NV);
      checks++;
      if (notePackets !== '0) begin errors++; $display("FAIL early_update: got %h required 0", notePackets); end
      tick(1);
      checks++;
      if (notePackets !== 96'h000000_000000_000000_010080) begin
         errors++; $display("FAIL single_packet: got %h required 010080 in voice0", notePackets);
      end
      checks++;
      if (voiceActive !== 4'b0001) begin errors++; $display("FAIL single_active: got %b required 0001", voiceActive); end
      checks++;
      if (stealPulse !== 1'b0) begin errors++; $display("FAIL single_steal: got %b required 0", stealPulse); end
      checks++;
      if (evReady !== 1'b1) begin errors++; $display("FAIL single_ready_again: got %b required 1", evReady); end
   endtask

   task automatic test_steal();
      do_event(1'b1, 7'd62, 16'h0110, 8'h81);
      do_event(1'b1, 7'd64, 16'h0120, 8'h82);
      do_event(1'b1, 7'd65, 16'h0130, 8'h83);
      checks++;
      if (stealPulse !== 1'b0) begin errors++; $display("FAIL fill_steal: got %b required 0", stealPulse); end
      checks++;
      if (voiceActive !== 4'b1111) begin errors++; $display("FAIL fill_active: got %b required 1111", voiceActive); end
      // voice0 has age 3 and is the oldest
      do_event(1'b1, 7'd67, 16'h0200, 8'h40);
      checks++;
      if (notePackets !== 96'h013083_012082_011081_020040) begin
         errors++; $display("FAIL steal_packets: got %h required 013083012082011081020040", notePackets);
      end
      checks++;
      if (stealPulse !== 1'b1) begin errors++; $display("FAIL steal_pulse: got %b required 1", stealPulse); end
      checks++;
      if (voiceActive !== 4'b1111) begin errors++; $display("FAIL steal_active: got %b required 1111", voiceActive); end
      tick(1);
      checks++;
      if (stealPulse !== 1'b0) begin errors++; $display("FAIL steal_pulse_width: got %b required 0", stealPulse); end
      // ages now v0=0 v1=3 v2=2 v3=1, so voice1 goes next
      do_event(1'b1, 7'd69, 16'h0210, 8'h41);
      checks++;
      if (notePackets !== 96'h013083_012082_021041_020040) begin
         errors++; $display("FAIL steal2_packets: got %h required 013083012082021041020040", notePackets);
      end
      checks++;
      if (stealPulse !== 1'b1) begin errors++; $display("FAIL steal2_pulse: got %b required 1", stealPulse); end
   endtask

   task automatic test_retrigger();
      do_reset();
      do_event(1'b1, 7'd60, 16'h0100, 8'h80);
      do_event(1'b1, 7'd60, 16'h0100, 8'h20);
      checks++;
      if (notePackets !== 96'h000000_000000_000000_010020) begin
         errors++; $display("FAIL retrig_packets: got %h required 010020 in voice0", notePackets);
      end
      checks++;
      if (voiceActive !== 4'b0001) begin errors++; $display("FAIL retrig_active: got %b required 0001", voiceActive); end
      checks++;
      if (stealPulse !== 1'b0) begin errors++; $display("FAIL retrig_steal: got %b required 0", stealPulse); end
   endtask

   task automatic test_note_off();
      do_event(1'b0, 7'd60, 16'h0000, 8'h00);
      checks++;
      if (notePackets !== 96'h000000_000000_000000_010000) begin
         errors++; $display("FAIL off_packets: got %h required 010000 in voice0", notePackets);
      end
      checks++;
      if (voiceActive !== 4'b0000) begin errors++; $display("FAIL off_active: got %b required 0000", voiceActive); end
      do_event(1'b0, 7'd99, 16'h0000, 8'h00);
      checks++;
      if (notePackets !== 96'h000000_000000_000000_010000) begin
         errors++; $display("FAIL off_nomatch_packets: got %h required 010000 in voice0", notePackets);
      end
      checks++;
      if (stealPulse !== 1'b0) begin errors++; $display("FAIL off_nomatch_steal: got %b required 0", stealPulse); end
   endtask

   task automatic test_zero_volume();
      do_event(1'b1, 7'd70, 16'h0300, 8'h50);
      checks++;
      if (notePackets !== 96'h000000_000000_000000_030050) begin
         errors++; $display("FAIL zv_alloc: got %h required 030050 in voice0", notePackets);
      end
      do_event(1'b1, 7'd70, 16'h0300, 8'h00);
      checks++;
      if (notePackets !== 96'h000000_000000_000000_030000) begin
         errors++; $display("FAIL zv_release: got %h required 030000 in voice0", notePackets);
      end
      checks++;
      if (voiceActive !== 4'b0000) begin errors++; $display("FAIL zv_active: got %b required 0000", voiceActive); end
      do_event(1'b1, 7'd71, 16'h0700, 8'h00);
      checks++;
      if ((notePackets !== 96'h000000_000000_000000_030000) || (voiceActive !== 4'b0000)) begin
         errors++; $display("FAIL zv_nomatch: got %h/%b required 030000 in voice0 / 0000", notePackets, voiceActive);
      end
   endtask

   task automatic test_back_to_back();
      logic [6:0]  keys [3];
      logic [15:0] tunes[3];
      logic [7:0]  vols [3];
      int acc_cyc[3];
      int n_acc;
      logic accepted;
      keys  = '{7'd80, 7'd81, 7'd82};
      tunes = '{16'h0400, 16'h0500, 16'h0600};
      vols  = '{8'h11, 8'h22, 8'h33};
      do_reset();
      n_acc      = 0;
      evValid    = 1'b1;
      evNoteOn   = 1'b1;
      evKey      = keys[0];
      evTuneWord = tunes[0];
      evVolume   = vols[0];
      for (int c = 0; c < 60 && n_acc < 3; c++) begin
         accepted = evReady && evValid;
         if (accepted) begin
            acc_cyc[n_acc] = c;
            n_acc++;
         end
         tick(1);
         if (accepted) begin
            if (n_acc < 3) begin
               evKey      = keys[n_acc];
               evTuneWord = tunes[n_acc];
               evVolume   = vols[n_acc];
            end else begin
               evValid = 1'b0;
            end
         end
      end
      evValid = 1'b0;
      checks++;
      if (n_acc !== 3) begin errors++; $display("FAIL b2b_count: got %0d accepts required 3", n_acc); end
      if (n_acc == 3) begin
         checks++;
         if ((acc_cyc[1] - acc_cyc[0]) !== NV + 2) begin
            errors++; $display("FAIL b2b_gap1: got %0d cycles required %0d", acc_cyc[1] - acc_cyc[0], NV + 2);
         end
         checks++;
         if ((acc_cyc[2] - acc_cyc[1]) !== NV + 2) begin
            errors++; $display("FAIL b2b_gap2: got %0d cycles required %0d", acc_cyc[2] - acc_cyc[1], NV + 2);
         end
      end
      tick(NV + 1);
      checks++;
      if (notePackets !== 96'h000000_060033_050022_040011) begin
         errors++; $display("FAIL b2b_packets: got %h required 000000060033050022040011", notePackets);
      end
      checks++;
      if (voiceActive !== 4'b0111) begin errors++; $display("FAIL b2b_active: got %b required 0111", voiceActive); end
   endtask

   task automatic test_reset_in_scan();
      send(1'b1, 7'd90, 16'h0900, 8'h99);
      tick(2);
      checks++;
      if (notePackets !== 96'h000000_060033_050022_040011) begin
         errors++; $display("FAIL scan_no_change: got %h required 000000060033050022040011", notePackets);
      end
      reset = 1'b0;
      #1;
      checks++;
      if (evReady !== 1'b0) begin errors++; $display("FAIL scan_rst_ready: got %b required 0", evReady); end
      tick(1);
      checks++;
      if ((notePackets !== '0) || (voiceActive !== '0) || (stealPulse !== 1'b0)) begin
         errors++; $display("FAIL scan_rst_outputs: got %h/%b/%b required all 0", notePackets, voiceActive, stealPulse);
      end
      reset = 1'b1;
      #1;
      checks++;
      if (evReady !== 1'b1) begin errors++; $display("FAIL scan_rst_release: got %b required 1", evReady); end
      tick(NV + 3);
      checks++;
      if ((notePackets !== '0) || (voiceActive !== '0)) begin
         errors++; $display("FAIL scan_rst_dropped: got %h/%b required all 0", notePackets, voiceActive);
      end
   endtask

   initial begin
      checks     = 0;
      errors     = 0;
      reset      = 1'b0;
      evValid    = 1'b0;
      evNoteOn   = 1'b0;
      evKey      = '0;
      evTuneWord = '0;
      evVolume   = '0;
      test_reset();
      test_single_note();
      test_steal();
      test_retrigger();
      test_note_off();
      test_zero_volume();
      test_back_to_back();
      test_reset_in_scan();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
